// File: rtl/aes_sched_pkg.sv
// Shared types and default sizing for the AES decrypt scheduler.
package aes_sched_pkg;

    localparam int NWORDS_DEF  = 16;
    localparam int AW_DEF      = 5;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN_RD,
        DRAIN_CAP,
        DRAIN_OUT
    } state_e;

endpackage

// File: rtl/aes_sched_ram_mux.sv
// Single-port RAM arbitration: the core owns the port only while granted.
module aes_sched_ram_mux
    import aes_sched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          grant_i,
    input  logic [AW-1:0] sch_addr_i,
    input  logic          sch_ce_i,
    input  logic          sch_we_i,
    input  logic [DW-1:0] sch_d_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic          core_ce_i,
    input  logic          core_we_i,
    input  logic [DW-1:0] core_d_i,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [DW-1:0] ram_d_o
);

    // Pick the port owner; an ungranted core can never reach the RAM.
    always_comb begin
        if (grant_i) begin
            ram_addr_o = core_addr_i;
            ram_ce_o   = core_ce_i;
            ram_we_o   = core_we_i;
            ram_d_o    = core_d_i;
        end else begin
            ram_addr_o = sch_addr_i;
            ram_ce_o   = sch_ce_i;
            ram_we_o   = sch_we_i;
            ram_d_o    = sch_d_i;
        end
    end

endmodule

// File: rtl/aes_decrypt_sched.sv
// Load / run / drain scheduler around one HLS aes_decrypt_call core.
module aes_decrypt_sched
    import aes_sched_pkg::*;
#(
    parameter int NWORDS  = NWORDS_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          core_start,
    input  logic          core_done,
    input  logic          core_ready,
    input  logic          core_idle,
    input  logic [AW-1:0] core_addr,
    input  logic          core_ce,
    input  logic          core_we,
    input  logic [DW-1:0] core_d,
    output logic [DW-1:0] core_q,
    output logic [AW-1:0] ram_addr,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          err,
    input  logic          err_clr,
    output logic [15:0]   blk_cnt
);

    localparam int             WDW      = $clog2(TIMEOUT) + 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(NWORDS - 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           m_valid_q, m_valid_d;
    logic           m_last_q, m_last_d;
    logic [DW-1:0]  m_data_q, m_data_d;
    logic [15:0]    blk_q, blk_d;

    logic           s_fire, m_fire, timeout;
    logic           grant, sch_ce, sch_we;

    // core_idle is status only and deliberately plays no part in control.
    logic unused_core_idle;
    assign unused_core_idle = core_idle;

    assign s_fire  = s_valid & (state_q == LOAD);
    assign m_fire  = m_valid_q & m_ready;
    assign timeout = (state_q == RUN) && (wd_q == WD_LIMIT);

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; a watchdog expiry wins over a same-cycle core_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = LOAD;
            LOAD:      if (s_fire && cnt_q == LAST_IDX) state_d = START;
            START:     if (core_ready) state_d = RUN;
            RUN: begin
                if (timeout)        state_d = IDLE;
                else if (core_done) state_d = DRAIN_RD;
            end
            DRAIN_RD:  state_d = DRAIN_CAP;
            DRAIN_CAP: state_d = DRAIN_OUT;
            DRAIN_OUT: if (m_fire) state_d = m_last_q ? IDLE : DRAIN_RD;
            default:   state_d = IDLE;
        endcase
    end

    // State-decoded outputs and the scheduler side of the RAM port.
    always_comb begin
        s_ready    = (state_q == LOAD);
        core_start = (state_q == START);
        busy       = (state_q != IDLE);
        grant      = (state_q == RUN);
        sch_we     = s_fire;
        sch_ce     = s_fire | (state_q == DRAIN_RD);
    end

    // Datapath next values: word counter, watchdog, error flag, output word.
    always_comb begin
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        blk_d     = blk_q;

        if (s_fire) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        if (m_fire) cnt_d = m_last_q ? '0 : cnt_q + 1'b1;

        if (state_q == START && core_ready) wd_d = '0;
        else if (state_q == RUN)            wd_d = wd_q + 1'b1;

        if (timeout)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;

        if (state_q == DRAIN_CAP) begin
            m_data_d  = ram_q;
            m_valid_d = 1'b1;
            m_last_d  = (cnt_q == LAST_IDX);
        end else if (m_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (m_fire && m_last_q) blk_d = blk_q + 16'd1;
    end

    // Datapath registers; reset discards any block in flight.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            blk_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            blk_q     <= blk_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign err     = err_q;
    assign blk_cnt = blk_q;
    assign core_q  = ram_q;

    aes_sched_ram_mux #(.AW(AW), .DW(DW)) u_ram_mux (
        .grant_i     (grant),
        .sch_addr_i  (cnt_q),
        .sch_ce_i    (sch_ce),
        .sch_we_i    (sch_we),
        .sch_d_i     (s_data),
        .core_addr_i (core_addr),
        .core_ce_i   (core_ce),
        .core_we_i   (core_we),
        .core_d_i    (core_d),
        .ram_addr_o  (ram_addr),
        .ram_ce_o    (ram_ce),
        .ram_we_o    (ram_we),
        .ram_d_o     (ram_d)
    );

endmodule

// File: tb/tb_aes_decrypt_sched.sv
// Directed bench for aes_decrypt_sched with a behavioural RAM and core driver.
module tb_aes_decrypt_sched;

    localparam int NW = 16;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4096;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          core_start, core_done, core_ready, core_idle;
    logic [AW-1:0] core_addr;
    logic          core_ce, core_we;
    logic [DW-1:0] core_d, core_q;
    logic [AW-1:0] ram_addr;
    logic          ram_ce, ram_we;
    logic [DW-1:0] ram_d, ram_q;
    logic          busy, err, err_clr;
    logic [15:0]   blk_cnt;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_err = 0;

    aes_decrypt_sched #(.NWORDS(NW), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .core_start (core_start),
        .core_done  (core_done),
        .core_ready (core_ready),
        .core_idle  (core_idle),
        .core_addr  (core_addr),
        .core_ce    (core_ce),
        .core_we    (core_we),
        .core_d     (core_d),
        .core_q     (core_q),
        .ram_addr   (ram_addr),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_d      (ram_d),
        .ram_q      (ram_q),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr),
        .blk_cnt    (blk_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge ap_clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_d;
            else        ram_q <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_rst();
        check("rst_s_ready",    s_ready,    0);
        check("rst_m_valid",    m_valid,    0);
        check("rst_m_last",     m_last,     0);
        check("rst_core_start", core_start, 0);
        check("rst_ram_ce",     ram_ce,     0);
        check("rst_ram_we",     ram_we,     0);
        check("rst_err",        err,        0);
        check("rst_m_data",     m_data,     0);
        check("rst_blk_cnt",    blk_cnt,    0);
        check("rst_busy",       busy,       0);
    endtask

    // Stream one block in, one word per cycle; START must follow immediately.
    task automatic load_block(input logic [31:0] base);
        for (int i = 0; i < NW; i++) begin
            @(negedge ap_clk);
            s_valid = 1'b1;
            s_data  = base + i;
            #1;
            check("ld_we",   {ram_ce, ram_we}, 2'b11);
            check("ld_addr", ram_addr, i);
            check("ld_d",    ram_d, base + i);
        end
        @(negedge ap_clk);
        s_valid = 1'b0;
        #1;
        check("st_core_start", core_start, 1);
        check("st_s_ready",    s_ready,    0);
    endtask

    // Hold core_ready low for nwait cycles, then accept the start.
    task automatic start_core(input int nwait);
        core_ce   = 1'b1;
        core_we   = 1'b1;
        core_addr = 5'd3;
        core_d    = 32'h55;
        #1;
        check("ign_ce", ram_ce, 0);
        check("ign_we", ram_we, 0);
        core_ce = 1'b0;
        core_we = 1'b0;
        for (int j = 0; j < nwait; j++) begin
            check("st_hold", core_start, 1);
            @(negedge ap_clk);
            #1;
        end
        core_ready = 1'b1;
        #1;
        check("st_acc", core_start, 1);
        @(negedge ap_clk);
        core_ready = 1'b0;
        #1;
        check("run_start_low", core_start, 0);
        check("run_busy",      busy,       1);
    endtask

    // Core writes base+i at address i, reads one word back, then signals done.
    task automatic core_run(input logic [31:0] base);
        for (int i = 0; i < NW; i++) begin
            core_ce   = 1'b1;
            core_we   = 1'b1;
            core_addr = AW'(i);
            core_d    = base + i;
            #1;
            check("run_we",   ram_we,   1);
            check("run_addr", ram_addr, i);
            check("run_d",    ram_d,    base + i);
            @(negedge ap_clk);
        end
        core_we   = 1'b0;
        core_addr = 5'd5;
        @(negedge ap_clk);
        core_ce = 1'b0;
        #1;
        check("core_q", core_q, base + 5);
        core_done = 1'b1;
        @(negedge ap_clk);
        core_done = 1'b0;
    endtask

    // Drain a block; optional stall word and reset-abort word (-1 = none).
    task automatic drain(input logic [31:0] base, input int stall_w, input int abort_w,
                         input logic [15:0] exp_blk);
        m_ready = 1'b0;
        for (int w = 0; w < NW; w++) begin
            int b = 0;
            while (!m_valid && b < 10) begin
                @(negedge ap_clk);
                b++;
            end
            check("dr_valid", m_valid, 1);
            if (w == abort_w) begin
                #2;
                ap_rst_n = 1'b0;
                #1;
                check_rst();
                return;
            end
            check("dr_data", m_data, base + w);
            check("dr_last", m_last, (w == NW - 1));
            if (w == stall_w) begin
                repeat (5) begin
                    @(negedge ap_clk);
                    check("stall_valid", m_valid, 1);
                    check("stall_data",  m_data,  base + w);
                    check("stall_last",  m_last,  0);
                end
            end
            m_ready = 1'b1;
            @(negedge ap_clk);
            m_ready = 1'b0;
            #1;
            check("dr_after_hs", m_valid, 0);
        end
        check("dr_idle", busy,    0);
        check("blk_cnt", blk_cnt, exp_blk);
    endtask

    initial begin
        int cycles;
        logic saw_mv;
        ap_rst_n   = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        core_done  = 1'b0;
        core_ready = 1'b0;
        core_idle  = 1'b1;
        core_addr  = '0;
        core_ce    = 1'b0;
        core_we    = 1'b0;
        core_d     = '0;
        err_clr    = 1'b0;

        repeat (2) @(negedge ap_clk);
        #1;
        check_rst();
        ap_rst_n = 1'b1;

        // Block 1: normal decrypt with a 5-cycle stall on word 7.
        load_block(32'h0000_0000);
        start_core(3);
        core_run(32'hDEAD_0000);
        drain(32'hDEAD_0000, 7, -1, 16'd1);

        // Block 2: core never finishes; watchdog fires, err_clr collides.
        load_block(32'h0000_0100);
        start_core(0);
        cycles = 0;
        saw_mv = 1'b0;
        while (!err && cycles < TO + 10) begin
            @(negedge ap_clk);
            cycles++;
            saw_mv  = saw_mv | m_valid;
            err_clr = (cycles == TO - 1);
        end
        err_clr = 1'b0;
        #1;
        check("to_cycles", cycles, TO);
        check("to_err",    err,    1);
        check("to_no_mv",  saw_mv, 0);
        check("to_idle",   busy,   0);
        check("to_blk",    blk_cnt, 1);
        @(negedge ap_clk);
        #1;
        check("to_reload",  s_ready, 1);
        check("err_sticky", err,     1);
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        #1;
        check("err_cleared", err, 0);

        // Block 3: reset asserted while word 4 is being offered.
        load_block(32'h0000_0200);
        start_core(1);
        core_run(32'hBEEF_0000);
        drain(32'hBEEF_0000, -1, 4, 16'd0);
        @(negedge ap_clk);
        #1;
        check("rst_hold_busy", busy, 0);
        ap_rst_n = 1'b1;

        // Block 4: full recovery after the abort.
        load_block(32'h0000_0300);
        start_core(2);
        core_run(32'hCAFE_0000);
        drain(32'hCAFE_0000, -1, -1, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
